// File: rtl/uart_cmd_responder.sv
// Byte-command responder on the parallel side of a UART: decodes read/write commands,
// drives a single-byte register bus and returns one response byte per command.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte in the rx buffer
// GET_DATA | write command seen, waiting (with timeout) for its data byte
// BUS_WR   | register write strobe, ACK queued as response
// BUS_RD   | register read strobe
// RD_CAP   | capture read data as response
// SEND     | wait for tx buffer empty, then load the response byte
// TX_HOLD  | dead cycle so the uart empty flag can drop
module uart_cmd_responder #(
   parameter int                    WIDTH_DATA = 8,
   parameter int                    WIDTH_ADDR = 7,
   parameter int                    TIMEOUT    = 50000,
   parameter int                    WIDTH_TO   = 16,
   parameter logic [WIDTH_DATA-1:0] ACK        = 8'h06,
   parameter logic [WIDTH_DATA-1:0] NAK        = 8'h15
) (
   input  logic                  i_clk,
   input  logic                  i_srst,
   input  logic [WIDTH_DATA-1:0] i_rx_data,
   input  logic                  i_rx_rdy,
   output logic                  o_rx_re,
   output logic [WIDTH_DATA-1:0] o_tx_data,
   output logic                  o_tx_we,
   input  logic                  i_tx_mty,
   output logic [WIDTH_ADDR-1:0] o_addr,
   output logic [WIDTH_DATA-1:0] o_wdata,
   output logic                  o_wr,
   output logic                  o_rd,
   input  logic [WIDTH_DATA-1:0] i_rdata,
   output logic                  o_busy,
   output logic                  o_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_GET_DATA,
      S_BUS_WR,
      S_BUS_RD,
      S_RD_CAP,
      S_SEND,
      S_TX_HOLD
   } state_t;

   localparam logic [WIDTH_TO-1:0] TO_LAST = WIDTH_TO'(TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [WIDTH_TO-1:0]   to_cnt, to_cnt_nxt;
   logic [WIDTH_ADDR-1:0] addr_nxt;
   logic [WIDTH_DATA-1:0] wdata_nxt;
   logic [WIDTH_DATA-1:0] tx_data_nxt;

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state     <= S_IDLE;
         to_cnt    <= '0;
         o_addr    <= '0;
         o_wdata   <= '0;
         o_tx_data <= '0;
      end else begin
         state     <= state_nxt;
         to_cnt    <= to_cnt_nxt;
         o_addr    <= addr_nxt;
         o_wdata   <= wdata_nxt;
         o_tx_data <= tx_data_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      to_cnt_nxt  = '0;
      addr_nxt    = o_addr;
      wdata_nxt   = o_wdata;
      tx_data_nxt = o_tx_data;
      o_rx_re     = 1'b0;
      o_tx_we     = 1'b0;
      o_wr        = 1'b0;
      o_rd        = 1'b0;
      o_err       = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_rx_rdy) begin
               o_rx_re   = 1'b1;
               addr_nxt  = i_rx_data[WIDTH_ADDR-1:0];
               state_nxt = i_rx_data[WIDTH_DATA-1] ? S_GET_DATA : S_BUS_RD;
            end
         end
         S_GET_DATA: begin
            // an arriving byte wins over a timeout expiring in the same cycle
            if (i_rx_rdy) begin
               o_rx_re   = 1'b1;
               wdata_nxt = i_rx_data;
               state_nxt = S_BUS_WR;
            end else if (to_cnt == TO_LAST) begin
               o_err       = 1'b1;
               tx_data_nxt = NAK;
               state_nxt   = S_SEND;
            end else begin
               to_cnt_nxt = to_cnt + 1'b1;
            end
         end
         S_BUS_WR: begin
            o_wr        = 1'b1;
            tx_data_nxt = ACK;
            state_nxt   = S_SEND;
         end
         S_BUS_RD: begin
            o_rd      = 1'b1;
            state_nxt = S_RD_CAP;
         end
         S_RD_CAP: begin
            tx_data_nxt = i_rdata;
            state_nxt   = S_SEND;
         end
         S_SEND: begin
            if (i_tx_mty) begin
               o_tx_we   = 1'b1;
               state_nxt = S_TX_HOLD;
            end
         end
         S_TX_HOLD: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      // strobes stay quiet during reset so no byte is popped and then dropped
      if (i_srst) begin
         o_rx_re = 1'b0;
         o_tx_we = 1'b0;
         o_wr    = 1'b0;
         o_rd    = 1'b0;
         o_err   = 1'b0;
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: models the uart rx/tx buffers and a register bank,
// runs a vector table, hand-written corner sequences and a randomized command stream.
module tb_uart_cmd_responder;
   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       srst;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       rx_re;
   logic [7:0] tx_data;
   logic       tx_we;
   logic       tx_mty;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       wr;
   logic       rd;
   logic [7:0] rdata;
   logic       busy;
   logic       err;

   always #5 clk = ~clk;

   uart_cmd_responder #(.TIMEOUT(TO), .WIDTH_TO(8)) dut (
      .i_clk(clk), .i_srst(srst),
      .i_rx_data(rx_data), .i_rx_rdy(rx_rdy), .o_rx_re(rx_re),
      .o_tx_data(tx_data), .o_tx_we(tx_we), .i_tx_mty(tx_mty),
      .o_addr(addr), .o_wdata(wdata), .o_wr(wr), .o_rd(rd), .i_rdata(rdata),
      .o_busy(busy), .o_err(err)
   );

   int n_total = 0;
   int n_pass  = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endfunction

   // environment: uart buffers and register bank
   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];
   int         we_times[$];
   int         pop_times[$];
   logic [7:0] regs[128];
   logic [7:0] mdl[128];
   logic [7:0] exp_q[$];
   int         cyc, t_pop, t_rd, t_wr, t_we, t_err;
   int         n_wr, n_rd, n_err, n_pop;
   logic [6:0] wr_addr, rd_addr, rd_addr_last;
   logic [7:0] wr_data;
   bit         rd_pend;
   int         mty_mode;

   task automatic drive_rx();
      rx_rdy  = (rx_q.size() != 0);
      rx_data = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      rx_q.push_back(b);
      drive_rx();
   endtask

   task automatic step();
      bit pop_now;
      pop_now = 1'b0;
      @(negedge clk);
      if (rx_re) begin
         chk("rx_re_needs_rdy", int'(rx_rdy), 1);
         pop_now = 1'b1; n_pop++; t_pop = cyc; pop_times.push_back(cyc);
      end
      if (tx_we) begin
         chk("tx_we_needs_mty", int'(tx_mty), 1);
         tx_log.push_back(tx_data); we_times.push_back(cyc); t_we = cyc;
      end
      if (wr) begin
         regs[addr] = wdata; wr_addr = addr; wr_data = wdata; n_wr++; t_wr = cyc;
      end
      if (rd) begin
         rd_pend = 1'b1; rd_addr = addr; rd_addr_last = addr; n_rd++; t_rd = cyc;
      end
      if (err) begin n_err++; t_err = cyc; end
      @(posedge clk);
      #1;
      cyc++;
      if (pop_now && rx_q.size() != 0) rx_q.delete(0);
      if (rd_pend) begin rdata = regs[rd_addr]; rd_pend = 1'b0; end
      else rdata = 8'($urandom_range(0, 255));
      case (mty_mode)
         0:       tx_mty = 1'b0;
         1:       tx_mty = 1'b1;
         default: tx_mty = 1'($urandom_range(0, 1));
      endcase
      drive_rx();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while ((busy || rx_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      chk(name, int'(n < budget), 1);
   endtask

   task automatic wait_pop(input string name);
      int p0, n;
      p0 = n_pop; n = 0;
      while (n_pop == p0 && n < 20) begin
         step();
         n++;
      end
      chk(name, int'(n_pop != p0), 1);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] data;
      bit         pre;
      logic [7:0] preval;
      logic [7:0] exp_resp;
      bit         is_wr;
      logic [6:0] exp_addr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0, s0, e0, pt0, bad;
      vecs[0] = '{8'h05, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0, 7'd5};
      vecs[1] = '{8'h8A, 8'h77, 1'b0, 8'h00, 8'h06, 1'b1, 7'd10};
      vecs[2] = '{8'h0A, 8'h00, 1'b0, 8'h00, 8'h77, 1'b0, 7'd10};
      vecs[3] = '{8'h7F, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b0, 7'd127};
      vecs[4] = '{8'hE0, 8'h00, 1'b0, 8'h00, 8'h06, 1'b1, 7'h60};
      vecs[5] = '{8'h60, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 7'h60};
      vecs[6] = '{8'h80, 8'hFF, 1'b0, 8'h00, 8'h06, 1'b1, 7'd0};
      vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b0, 7'd0};

      srst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; tx_mty = 1'b1; rdata = 8'h00;
      mty_mode = 1; cyc = 0; n_wr = 0; n_rd = 0; n_err = 0; n_pop = 0; rd_pend = 1'b0;
      t_pop = 0; t_rd = 0; t_wr = 0; t_we = 0; t_err = 0;
      for (int i = 0; i < 128; i++) regs[i] = 8'($urandom_range(0, 255));
      regs[5] = 8'h3C;

      // byte waiting during reset must not be popped
      push(8'h05);
      repeat (3) step();
      chk("rst_rx_re", int'(rx_re), 0);
      chk("rst_rx_kept", rx_q.size(), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr", int'(addr), 0);
      chk("rst_wdata", int'(wdata), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_strobes", int'({tx_we, wr, rd, err}), 0);
      srst = 1'b0;
      s0 = tx_log.size();
      wait_idle("rst_then_read_idle", 50);
      chk("rst_then_read_count", tx_log.size() - s0, 1);
      if (tx_log.size() > s0) chk("rst_then_read_resp", int'(tx_log[s0]), 8'h3C);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].pre) regs[vecs[i].exp_addr] = vecs[i].preval;
         w0 = n_wr; r0 = n_rd; s0 = tx_log.size();
         push(vecs[i].cmd);
         if (vecs[i].is_wr) push(vecs[i].data);
         wait_idle("vec_idle", 50);
         chk("vec_resp_count", tx_log.size() - s0, 1);
         if (tx_log.size() > s0) chk("vec_resp", int'(tx_log[s0]), int'(vecs[i].exp_resp));
         if (vecs[i].is_wr) begin
            chk("vec_wr_count", n_wr - w0, 1);
            chk("vec_rd_none", n_rd - r0, 0);
            chk("vec_wr_addr", int'(wr_addr), int'(vecs[i].exp_addr));
            chk("vec_wdata", int'(wr_data), int'(vecs[i].data));
            chk("lat_wr", t_wr - t_pop, 1);
            chk("lat_wr_we", t_we - t_pop, 2);
         end else begin
            chk("vec_rd_count", n_rd - r0, 1);
            chk("vec_wr_none", n_wr - w0, 0);
            chk("vec_rd_addr", int'(rd_addr_last), int'(vecs[i].exp_addr));
            chk("lat_rd", t_rd - t_pop, 1);
            chk("lat_rd_we", t_we - t_pop, 3);
         end
         chk("vec_busy_after", int'(busy), 0);
      end

      // write whose data byte never arrives
      e0 = n_err; w0 = n_wr; s0 = tx_log.size();
      push(8'h81);
      wait_idle("to_idle", 60);
      chk("to_err_count", n_err - e0, 1);
      chk("to_err_lat", t_err - t_pop, TO);
      chk("to_no_wr", n_wr - w0, 0);
      chk("to_resp_count", tx_log.size() - s0, 1);
      if (tx_log.size() > s0) chk("to_resp", int'(tx_log[s0]), 8'h15);

      // data byte arriving in the very cycle the timeout would expire
      e0 = n_err; w0 = n_wr; s0 = tx_log.size();
      push(8'h82);
      wait_pop("edge_cmd_pop");
      repeat (TO - 1) step();
      push(8'h5E);
      wait_idle("edge_idle", 20);
      chk("edge_no_err", n_err - e0, 0);
      chk("edge_wr_count", n_wr - w0, 1);
      chk("edge_wr_addr", int'(wr_addr), 2);
      chk("edge_wdata", int'(wr_data), 8'h5E);
      chk("edge_resp_count", tx_log.size() - s0, 1);
      if (tx_log.size() > s0) chk("edge_resp", int'(tx_log[s0]), 8'h06);

      // tx backpressure
      regs[7'h11] = 8'h5A;
      mty_mode = 0; tx_mty = 1'b0;
      s0 = tx_log.size();
      push(8'h11);
      repeat (100) step();
      chk("bp_no_we", tx_log.size() - s0, 0);
      chk("bp_busy", int'(busy), 1);
      chk("bp_hold_data", int'(tx_data), 8'h5A);
      mty_mode = 1; tx_mty = 1'b1;
      wait_idle("bp_idle", 20);
      chk("bp_resp_count", tx_log.size() - s0, 1);
      if (tx_log.size() > s0) chk("bp_resp", int'(tx_log[s0]), 8'h5A);

      // reset while waiting for write data
      w0 = n_wr; e0 = n_err; s0 = tx_log.size();
      push(8'h83);
      wait_pop("mid_rst_pop");
      chk("mid_rst_busy_before", int'(busy), 1);
      srst = 1'b1;
      step();
      srst = 1'b0;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_addr", int'(addr), 0);
      chk("mid_rst_wdata", int'(wdata), 0);
      chk("mid_rst_tx_data", int'(tx_data), 0);
      repeat (30) step();
      chk("mid_rst_no_wr", n_wr - w0, 0);
      chk("mid_rst_no_err", n_err - e0, 0);
      chk("mid_rst_no_resp", tx_log.size() - s0, 0);
      regs[3] = 8'hC3;
      push(8'h03);
      wait_idle("mid_rst_read_idle", 50);
      chk("mid_rst_read_count", tx_log.size() - s0, 1);
      if (tx_log.size() > s0) chk("mid_rst_read_resp", int'(tx_log[s0]), 8'hC3);

      // two reads queued back to back
      regs[5] = 8'h11; regs[6] = 8'h22;
      pt0 = pop_times.size(); s0 = tx_log.size();
      push(8'h05); push(8'h06);
      wait_idle("b2b_idle", 50);
      chk("b2b_count", tx_log.size() - s0, 2);
      if (tx_log.size() > s0 + 1) begin
         chk("b2b_first", int'(tx_log[s0]), 8'h11);
         chk("b2b_second", int'(tx_log[s0+1]), 8'h22);
      end
      if (pop_times.size() > pt0 + 1 && we_times.size() > s0)
         chk("b2b_gap", pop_times[pt0+1] - we_times[s0], 2);

      // random command stream against a plain register-array model
      mty_mode = 2;
      mdl = regs;
      exp_q.delete();
      s0 = tx_log.size();
      for (int i = 0; i < 40; i++) begin
         logic [6:0] a;
         logic [7:0] d;
         a = 7'($urandom_range(0, 127));
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) begin
            push({1'b1, a}); push(d);
            mdl[a] = d;
            exp_q.push_back(8'h06);
         end else begin
            push({1'b0, a});
            exp_q.push_back(mdl[a]);
         end
      end
      wait_idle("rand_idle", 2000);
      chk("rand_resp_count", tx_log.size() - s0, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (s0 + i < tx_log.size()) chk("rand_resp", int'(tx_log[s0+i]), int'(exp_q[i]));
      bad = 0;
      for (int i = 0; i < 128; i++) if (regs[i] !== mdl[i]) bad++;
      chk("rand_regs", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
